// File: rtl/rot_share_ctrl_pkg.sv
// Shared constants for the round-robin shifter-sharing controller:
// FSM state encoding and the datapath width.
package rot_share_ctrl_pkg;
    localparam int DW = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
endpackage

// File: rtl/rot_share_ctrl_arb.sv
// Combinational round-robin arbiter: first valid requester at or after rr_ptr,
// wrapping from NREQ-1 back to 0. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);
    logic w_found;
    int   w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = (int'(rr_ptr) + k) % NREQ;
            if (!w_found && req_valid[w_idx]) begin
                w_found     = 1'b1;
                gnt[w_idx]  = 1'b1;
                gnt_id      = w_idx[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/rot_share_ctrl_shifter.sv
// 4-bit left rotator by sel positions, built twice: a behavioural form and a
// two-stage mux form, so the caller can cross-check them.
module barrel_shifter
    import rot_share_ctrl_pkg::*;
(
    input  logic [DW-1:0] x,
    input  logic [1:0]    sel,
    output logic [DW-1:0] y_beh,
    output logic [DW-1:0] y_struct
);
    logic [DW-1:0] w_stage1;

    always_comb begin
        y_beh = x;
        case (sel)
            2'd0:    y_beh = x;
            2'd1:    y_beh = {x[2:0], x[3]};
            2'd2:    y_beh = {x[1:0], x[3:2]};
            default: y_beh = {x[0], x[3:1]};
        endcase
    end

    assign w_stage1 = sel[0] ? {x[2:0], x[3]} : x;
    assign y_struct = sel[1] ? {w_stage1[1:0], w_stage1[3:2]} : w_stage1;
endmodule

// File: rtl/rot_share_ctrl.sv
// Shares one barrel_shifter between NREQ requesters: round-robin grant in IDLE,
// one SHIFT cycle on the latched operand, then hold the tagged result in RESP.
module rot_share_ctrl
    import rot_share_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_x,
    input  logic [NREQ*2-1:0]  req_sel,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_y,
    output logic               err,
    output logic [1:0]         dbg_state
);
    // Handshake: a request moves when req_valid[i] & req_ready[i] at a clock
    // edge; a result moves when rsp_valid & rsp_ready at a clock edge.
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [IDW-1:0]  r_gnt_id;
    logic [DW-1:0]   r_x;
    logic [1:0]      r_sel;
    logic [DW-1:0]   r_rsp_y;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_err;
    logic [NREQ-1:0] w_gnt;
    logic [IDW-1:0]  w_gnt_id;
    logic            w_accept;
    logic [DW-1:0]   w_y_beh;
    logic [DW-1:0]   w_y_struct;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .gnt       (w_gnt),
        .gnt_id    (w_gnt_id)
    );

    barrel_shifter u_shift (
        .x        (r_x),
        .sel      (r_sel),
        .y_beh    (w_y_beh),
        .y_struct (w_y_struct)
    );

    assign w_accept  = (r_state == ST_IDLE) && (|w_gnt);
    assign w_ptr_nxt = (w_gnt_id == IDW'(NREQ - 1)) ? '0 : w_gnt_id + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (|w_gnt) w_state_nxt = ST_SHIFT;
            ST_SHIFT: w_state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant is gated by rst_n so req_ready reads 0 for the whole reset window.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        if (r_state == ST_IDLE && rst_n) req_ready = w_gnt;
        if (r_state == ST_RESP)          rsp_valid = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_gnt_id <= '0;
            r_x      <= '0;
            r_sel    <= '0;
            r_rsp_y  <= '0;
            r_rsp_id <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x      <= req_x[int'(w_gnt_id)*DW +: DW];
                r_sel    <= req_sel[int'(w_gnt_id)*2 +: 2];
                r_gnt_id <= w_gnt_id;
                r_rr_ptr <= w_ptr_nxt;
            end
            if (r_state == ST_SHIFT) begin
                r_rsp_y  <= w_y_beh;
                r_rsp_id <= r_gnt_id;
                if (w_y_beh != w_y_struct) r_err <= 1'b1;
            end
        end
    end

    assign rsp_y     = r_rsp_y;
    assign rsp_id    = r_rsp_id;
    assign err       = r_err;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_rot_share_ctrl.sv
// Directed bench for rot_share_ctrl: a 2-requester instance driven from a
// vector table plus stall/reset sequences, and a 4-requester instance for wrap.
module tb_rot_share_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [7:0]  req_x;
    logic [3:0]  req_sel;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [3:0]  rsp_y;
    logic        err;
    logic [1:0]  dbg_state;

    logic [3:0]  req_valid4;
    logic [15:0] req_x4;
    logic [7:0]  req_sel4;
    logic [3:0]  req_ready4;
    logic        rsp_valid4;
    logic        rsp_ready4;
    logic [1:0]  rsp_id4;
    logic [3:0]  rsp_y4;
    logic        err4;
    logic [1:0]  dbg_state4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rot_share_ctrl #(.NREQ(2), .IDW(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_x(req_x),
        .req_sel(req_sel), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .err(err),
        .dbg_state(dbg_state)
    );

    rot_share_ctrl #(.NREQ(4), .IDW(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_x(req_x4),
        .req_sel(req_sel4), .req_ready(req_ready4), .rsp_valid(rsp_valid4),
        .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_y(rsp_y4), .err(err4),
        .dbg_state(dbg_state4)
    );

    typedef struct {
        logic [1:0] valid;
        logic [7:0] x;
        logic [3:0] sel;
        logic [1:0] exp_gnt;
        logic       exp_id;
        logic [3:0] exp_y;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_valid4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_err", err, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst4_rsp_valid", rsp_valid4, 0);
        rst_n = 1'b1;
    endtask

    // Starts at a negedge with the DUT in IDLE and rsp_ready=1; ends at the
    // negedge where it is back in IDLE.
    task automatic run_op(input logic [1:0] v, input logic [7:0] x, input logic [3:0] s,
                          input logic [1:0] eg, input logic eid, input logic [3:0] ey);
        req_valid = v;
        req_x     = x;
        req_sel   = s;
        #1;
        chk("grant", req_ready, eg);
        @(negedge clk);
        chk("shift_state", dbg_state, 1);
        chk("shift_ready", req_ready, 0);
        chk("shift_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_id", rsp_id, eid);
        chk("resp_y", rsp_y, ey);
        chk("resp_err", err, 0);
        @(negedge clk);
    endtask

    task automatic run_op4(input logic [3:0] v, input logic [3:0] eg,
                           input logic [1:0] eid, input logic [3:0] ey);
        req_valid4 = v;
        #1;
        chk("grant4", req_ready4, eg);
        @(negedge clk);
        chk("shift4_ready", req_ready4, 0);
        @(negedge clk);
        chk("resp4_valid", rsp_valid4, 1);
        chk("resp4_id", rsp_id4, eid);
        chk("resp4_y", rsp_y4, ey);
        chk("resp4_err", err4, 0);
        @(negedge clk);
    endtask

    initial begin
        // Rotation is left by sel; req0 nibble at x[3:0], req1 at x[7:4].
        vecs[0]  = '{2'b01, 8'h01, 4'b0001, 2'b01, 1'b0, 4'b0010};
        vecs[1]  = '{2'b11, 8'hA3, 4'b1101, 2'b01, 1'b0, 4'b0110};
        vecs[2]  = '{2'b11, 8'hA3, 4'b1101, 2'b10, 1'b1, 4'b0101};
        vecs[3]  = '{2'b11, 8'hA3, 4'b1101, 2'b01, 1'b0, 4'b0110};
        vecs[4]  = '{2'b11, 8'hA3, 4'b1101, 2'b10, 1'b1, 4'b0101};
        vecs[5]  = '{2'b10, 8'h8F, 4'b0010, 2'b10, 1'b1, 4'b1000};
        vecs[6]  = '{2'b10, 8'h8F, 4'b0110, 2'b10, 1'b1, 4'b0001};
        vecs[7]  = '{2'b10, 8'h8F, 4'b1010, 2'b10, 1'b1, 4'b0010};
        vecs[8]  = '{2'b10, 8'h8F, 4'b1110, 2'b10, 1'b1, 4'b0100};
        vecs[9]  = '{2'b10, 8'h1F, 4'b0010, 2'b10, 1'b1, 4'b0001};
        vecs[10] = '{2'b10, 8'h1F, 4'b0110, 2'b10, 1'b1, 4'b0010};
        vecs[11] = '{2'b10, 8'h1F, 4'b1010, 2'b10, 1'b1, 4'b0100};
        vecs[12] = '{2'b10, 8'h1F, 4'b1110, 2'b10, 1'b1, 4'b1000};

        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_sel    = '0;
        rsp_ready  = 1'b1;
        req_valid4 = '0;
        req_x4     = {4'h8, 4'h4, 4'h2, 4'h1};
        req_sel4   = 8'b01_01_01_01;
        rsp_ready4 = 1'b1;

        do_reset();
        for (int i = 0; i < 13; i++) begin
            if (i == 1) do_reset();
            run_op(vecs[i].valid, vecs[i].x, vecs[i].sel,
                   vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_y);
        end

        // Response stall: result must hold while rsp_ready=0.
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        req_x     = 8'h06;
        req_sel   = 4'b0010;
        #1;
        chk("stall_grant", req_ready, 2'b01);
        repeat (2) @(negedge clk);
        chk("stall_resp_y", rsp_y, 4'b1001);
        req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_y", rsp_y, 4'b1001);
            chk("stall_id", rsp_id, 0);
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_done_valid", rsp_valid, 0);
        chk("stall_done_state", dbg_state, 0);
        chk("stall_next_grant", req_ready, 2'b10);
        req_valid = 2'b00;
        #1;
        chk("drop_no_grant", req_ready, 0);
        @(negedge clk);
        chk("drop_stays_idle", dbg_state, 0);

        // Reset in the middle of an operation.
        req_valid = 2'b01;
        req_x     = 8'h01;
        req_sel   = 4'b0011;
        @(negedge clk);
        chk("midrst_shift", dbg_state, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_state", dbg_state, 0);
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_ready", req_ready, 0);
        chk("midrst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b01, 8'h02, 4'b0001, 2'b01, 1'b0, 4'b0100);
        req_valid = 2'b00;

        // Four requesters: park the pointer at 3, then check the wrap order.
        run_op4(4'b0100, 4'b0100, 2'd2, 4'b1000);
        run_op4(4'b0101, 4'b0001, 2'd0, 4'b0010);
        run_op4(4'b0101, 4'b0100, 2'd2, 4'b1000);
        run_op4(4'b0101, 4'b0001, 2'd0, 4'b0010);
        req_valid4 = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
